mips_hazard_unit: RTL

Parametrised hazard and forwarding controller for the five-stage MIPS pipeline. It keeps its own shadow pipeline of destination and source register tags, one per stage from ID/EX to MEM/WB. From these it produces ALU-operand forwarding selects, load-use stalls (PC and IF/ID hold plus an ID/EX bubble) and control-hazard flushes for taken branches and jumps. It sits beside the pipeline registers in the datapath top and drives their write-enable and flush inputs.

---
 rtl/mips_pkg.sv | 54 +++++
 rtl/mips_hazard_unit_if.sv | 50 +++++
 rtl/hazard_sat_cnt.sv | 32 +++
 rtl/mips_hazard_unit.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared definitions for the MIPS hazard/forwarding controller.
//               Forwarding select encodings, branch-resolve stage encodings,
//               the shadow-pipeline stage record and the forwarding helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // ALU operand source selects
    localparam logic [1:0] FWD_REG   = 2'd0;  // register file
    localparam logic [1:0] FWD_EXMEM = 2'd1;  // EX/MEM ALU result
    localparam logic [1:0] FWD_MEMWB = 2'd2;  // MEM/WB write-back data

    // Stage in which a branch resolves
    localparam int BR_EX  = 2;
    localparam int BR_MEM = 3;

    // Register tags are stored zero-extended to a fixed width so a single
    // record type serves every REG_AW up to this size.
    localparam int TAG_AW = 8;

    typedef struct packed {
        logic              valid;
        logic              wr_en;
        logic [TAG_AW-1:0] wr_reg;
        logic              mem_read;
        logic [TAG_AW-1:0] rs;
        logic [TAG_AW-1:0] rt;
        logic              use_rs;
        logic              use_rt;
    } stage_tag_t;

    // Select the freshest producer of src; MEM is younger than WB so it wins.
    // Register 0 is never forwarded because it always reads as zero.
    function automatic logic [1:0] fwd_select(input logic              use_src,
                                              input logic [TAG_AW-1:0] src,
                                              input stage_tag_t        mem,
                                              input stage_tag_t        wb);
        logic [1:0] sel;
        sel = FWD_REG;
        if (use_src && (src != '0)) begin
            if (mem.valid && mem.wr_en && (mem.wr_reg == src)) begin
                sel = FWD_EXMEM;
            end else if (wb.valid && wb.wr_en && (wb.wr_reg == src)) begin
                sel = FWD_MEMWB;
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_hazard_unit_if
// Description : Bundle between the datapath (master) and the hazard unit
//               (slave). Master drives ID-stage decode info and branch
//               outcome; slave returns write enables, flushes, forwarding
//               selects and the event counters.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wr_en;
    logic [REG_AW-1:0] id_wr_reg;
    logic              id_mem_read;
    logic              id_jump;
    logic              br_taken;

    logic              pc_we;
    logic              ifid_we;
    logic              idex_bubble;
    logic              flush_ifid;
    logic              flush_idex;
    logic              flush_exmem;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en,
               id_wr_reg, id_mem_read, id_jump, br_taken,
        input  pc_we, ifid_we, idex_bubble, flush_ifid, flush_idex,
               flush_exmem, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en,
               id_wr_reg, id_mem_read, id_jump, br_taken,
        output pc_we, ifid_we, idex_bubble, flush_ifid, flush_idex,
               flush_exmem, fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sat_cnt
// Description : Saturating up-counter. Adds one per cycle with inc high and
//               sticks at all-ones.
// Ports       : clk, rst_n (async active-low), inc, count[WIDTH-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             inc,
    output logic [WIDTH-1:0]      count
);
    localparam logic [WIDTH-1:0] C_MAX = '1;

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != C_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/mips_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : mips_hazard_unit
// Description : Hazard and forwarding controller for the 5-stage MIPS pipe.
//               Tracks EX/MEM/WB register tags in a shadow pipeline and
//               produces forwarding selects, load-use stalls and
//               branch/jump flushes, all combinational in the same cycle.
// Ports       : Eclk  - pipeline clock, rising edge
//               rst_n - asynchronous active-low reset
//               hz    - slave side of mips_hazard_unit_if
// Revision    : 1.0 - initial release
// ============================================================================
module mips_hazard_unit
    import mips_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int BR_STAGE = BR_MEM,  // 2 = EX, 3 = MEM
    parameter int CNT_W    = 16
) (
    input wire logic          Eclk,
    input wire logic          rst_n,
    mips_hazard_unit_if.slave hz
);
    localparam int C_EX  = 0;
    localparam int C_MEM = 1;
    localparam int C_WB  = 2;

    stage_tag_t r_stage [3];
    stage_tag_t w_id_tag;

    logic       w_br_mem;
    logic       w_load_use;
    logic       w_stall;
    logic       w_flush_ifid;
    logic       w_flush_idex;
    logic       w_flush_exmem;
    logic       w_pc_we;
    logic       w_ifid_we;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // A MEM-resolved branch also has a wrong-path instruction in EX.
    if (BR_STAGE == BR_MEM) begin : g_br_mem
        assign w_br_mem = 1'b1;
    end else begin : g_br_ex
        assign w_br_mem = 1'b0;
    end

    always_comb begin
        w_id_tag          = '0;
        w_id_tag.valid    = hz.id_valid;
        w_id_tag.wr_en    = hz.id_wr_en;
        w_id_tag.wr_reg   = TAG_AW'(hz.id_wr_reg[REG_AW-1:0]);
        w_id_tag.mem_read = hz.id_mem_read;
        w_id_tag.rs       = TAG_AW'(hz.id_rs[REG_AW-1:0]);
        w_id_tag.rt       = TAG_AW'(hz.id_rt[REG_AW-1:0]);
        w_id_tag.use_rs   = hz.id_use_rs;
        w_id_tag.use_rt   = hz.id_use_rt;
    end

    // Load in EX whose destination is a source of the instruction in ID.
    assign w_load_use = hz.id_valid && r_stage[C_EX].valid &&
                        r_stage[C_EX].mem_read && (r_stage[C_EX].wr_reg != '0) &&
                        ((hz.id_use_rs && (w_id_tag.rs == r_stage[C_EX].wr_reg)) ||
                         (hz.id_use_rt && (w_id_tag.rt == r_stage[C_EX].wr_reg)));

    // Outputs are forced to their idle values while reset is held so an
    // in-progress stall drops without waiting for a clock edge.
    always_comb begin
        w_stall       = 1'b0;
        w_flush_ifid  = 1'b0;
        w_flush_idex  = 1'b0;
        w_flush_exmem = 1'b0;
        w_pc_we       = 1'b1;
        w_ifid_we     = 1'b1;
        w_fwd_a       = FWD_REG;
        w_fwd_b       = FWD_REG;
        if (rst_n) begin
            // A taken branch kills the dependant anyway, so it overrides
            // the stall; a jump waits until the stall has cleared.
            w_stall       = w_load_use && !hz.br_taken;
            w_flush_ifid  = hz.br_taken || (hz.id_jump && !w_load_use);
            w_flush_idex  = hz.br_taken;
            w_flush_exmem = hz.br_taken && w_br_mem;
            w_pc_we       = !w_stall;
            w_ifid_we     = !w_stall;
            w_fwd_a = fwd_select(r_stage[C_EX].use_rs, r_stage[C_EX].rs,
                                 r_stage[C_MEM], r_stage[C_WB]);
            w_fwd_b = fwd_select(r_stage[C_EX].use_rt, r_stage[C_EX].rt,
                                 r_stage[C_MEM], r_stage[C_WB]);
        end
    end

    always_ff @(posedge Eclk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage[C_EX]  <= '0;
            r_stage[C_MEM] <= '0;
            r_stage[C_WB]  <= '0;
        end else begin
            r_stage[C_EX]  <= (w_stall || w_flush_idex) ? '0 : w_id_tag;
            r_stage[C_MEM] <= w_flush_exmem ? '0 : r_stage[C_EX];
            r_stage[C_WB]  <= r_stage[C_MEM];
        end
    end

    hazard_sat_cnt #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (Eclk),
        .rst_n (rst_n),
        .inc   (w_stall),
        .count (hz.stall_cnt)
    );

    hazard_sat_cnt #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (Eclk),
        .rst_n (rst_n),
        .inc   (w_flush_ifid || w_flush_idex || w_flush_exmem),
        .count (hz.flush_cnt)
    );

    assign hz.pc_we       = w_pc_we;
    assign hz.ifid_we     = w_ifid_we;
    assign hz.idex_bubble = w_stall;
    assign hz.flush_ifid  = w_flush_ifid;
    assign hz.flush_idex  = w_flush_idex;
    assign hz.flush_exmem = w_flush_exmem;
    assign hz.fwd_a       = w_fwd_a;
    assign hz.fwd_b       = w_fwd_b;

endmodule
`default_nettype wire
